key_mode_fsm: RTL and testbench



---
 rtl/key_mode_fsm.sv | 142 ++++++++++++++
 tb/tb_key_mode_fsm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/key_mode_fsm.sv
// Two-button mode sequencer: debounced next/prev keys step a wrapping mode index,
// a long next-press returns to IDLE, and the LED bank shows a per-mode pattern.
module key_mode_fsm #(
  parameter int NUM_MODES    = 4,
  parameter int LED_W        = 8,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LONG_CYC     = 100000000,
  parameter int BLINK_CYC    = 25000000,
  parameter logic [LED_W-1:0] IDLE_PATTERN = LED_W'('hAA),
  localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_next,
  input  logic              key_prev,
  output logic [MODE_W-1:0] mode,
  output logic              key_evt,
  output logic [LED_W-1:0]  led
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int LONG_W  = $clog2(LONG_CYC + 1);
  localparam int BLINK_W = $clog2(BLINK_CYC + 1);

  localparam logic [MODE_W-1:0]  MODE_IDLE  = '0;
  localparam logic [MODE_W-1:0]  MODE_LAST  = MODE_W'(NUM_MODES - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [LONG_W-1:0]  LONG_MAX   = LONG_W'(LONG_CYC);
  localparam logic [LONG_W-1:0]  LONG_LAST  = LONG_W'(LONG_CYC - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYC - 1);

  // Bit 0 is the next key, bit 1 the prev key; all levels are active-low.
  logic [1:0]      raw, sync1, sync2, db, db_q, press;
  logic [DB_W-1:0] db_cnt [2];

  assign raw = {key_prev, key_next};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
      db    <= '1;
      db_q  <= '1;
      press <= '0;
      // NOTE: the small counter array is plain flops, so it is reset like any
      // other register; a RAM-backed array would be left unreset instead.
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      db_q  <= db;
      press <= db_q & ~db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Long-press counter saturates at LONG_CYC so only one pulse fires per hold.
  logic [LONG_W-1:0] long_cnt;
  logic              long_pulse;

  always_ff @(posedge clk) begin
    if (rst || db[0]) begin
      long_cnt   <= '0;
      long_pulse <= 1'b0;
    end else if (long_cnt != LONG_MAX) begin
      long_cnt   <= long_cnt + LONG_W'(1);
      long_pulse <= (long_cnt == LONG_LAST);
    end else begin
      long_pulse <= 1'b0;
    end
  end

  logic [MODE_W-1:0] mode_nxt;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    mode_nxt = mode;
    if (long_pulse) begin
      mode_nxt = MODE_IDLE;
    end else if (press[0] && !press[1]) begin
      mode_nxt = (mode == MODE_LAST) ? MODE_IDLE : mode + MODE_W'(1);
    end else if (press[1] && !press[0]) begin
      mode_nxt = (mode == MODE_IDLE) ? MODE_LAST : mode - MODE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode    <= MODE_IDLE;
      key_evt <= 1'b0;
    end else begin
      mode    <= mode_nxt;
      key_evt <= (mode_nxt != mode);
    end
  end

  logic [LED_W-1:0] led_onehot;

  always_comb begin
    led_onehot = '0;
    for (int i = 0; i < LED_W; i++) begin
      if (((int'(mode) - 1) % LED_W) == i) led_onehot[i] = 1'b1;
    end
  end

  // Blink timer is held clear outside IDLE, so each entry starts on IDLE_PATTERN.
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      led         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (mode != MODE_IDLE) begin
      led         <= led_onehot;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      led <= blink_phase ? ~IDLE_PATTERN : IDLE_PATTERN;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_key_mode_fsm.sv
// Directed bench for key_mode_fsm: stimulus queues expected mode events with their
// cycle stamps, and a negedge monitor pops and checks them whenever key_evt fires.
module tb_key_mode_fsm;

  localparam int NUM_MODES    = 4;
  localparam int LED_W        = 8;
  localparam int DEBOUNCE_CYC = 4;
  localparam int LONG_CYC     = 20;
  localparam int BLINK_CYC    = 8;

  // Key driven low after cycle t: sync 2, debounce 4, press +1, mode +1.
  localparam int PRESS_LAT = 2 + DEBOUNCE_CYC + 2;
  // Long pulse LONG_CYC cycles after db falls, mode one cycle later.
  localparam int LONG_LAT  = 2 + DEBOUNCE_CYC + LONG_CYC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_next;
  logic       key_prev;
  logic [1:0] mode;
  logic       key_evt;
  logic [7:0] led;

  key_mode_fsm #(
    .NUM_MODES   (NUM_MODES),
    .LED_W       (LED_W),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .LONG_CYC    (LONG_CYC),
    .BLINK_CYC   (BLINK_CYC),
    .IDLE_PATTERN(8'hAA)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .key_next(key_next),
    .key_prev(key_prev),
    .mode    (mode),
    .key_evt (key_evt),
    .led     (led)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int         mode;
    logic [7:0] led;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  int   exp_mode;

  function automatic logic [7:0] led_of(input int m);
    logic [7:0] one;
    one = 8'h01;
    return (m == 0) ? 8'hAA : (one << ((m - 1) % LED_W));
  endfunction

  task automatic sb_push(input int nm, input int at);
    exp_t e;
    if (nm != exp_mode) begin
      e.mode = nm;
      e.led  = led_of(nm);
      e.at   = at;
      exp_q.push_back(e);
    end
    exp_mode = nm;
  endtask

  task automatic press(input bit nxt, input bit prv, input int hold, input int rel);
    int t;
    int nm;
    @(negedge clk);
    key_next = ~nxt;
    key_prev = ~prv;
    t = cyc;
    if (nxt && !prv)      nm = (exp_mode + 1) % NUM_MODES;
    else if (prv && !nxt) nm = (exp_mode + NUM_MODES - 1) % NUM_MODES;
    else                  nm = exp_mode;
    sb_push(nm, t + PRESS_LAT);
    if (nxt && hold > LONG_LAT) sb_push(0, t + LONG_LAT);
    repeat (hold) @(negedge clk);
    key_next = 1'b1;
    key_prev = 1'b1;
    repeat (rel) @(negedge clk);
  endtask

  // Monitor: each key_evt must match the head of the queue in mode and cycle,
  // and the LED must show the expected pattern one cycle later.
  logic       led_pend = 1'b0;
  logic [7:0] led_exp;

  always @(negedge clk) begin
    exp_t e;
    if (led_pend) begin
      check("led_after_evt", 32'(led), 32'(led_exp));
      led_pend = 1'b0;
    end
    if (!rst && key_evt === 1'b1) begin
      check("evt_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("evt_mode", 32'(mode), 32'(e.mode));
        check("evt_cycle", 32'(cyc), 32'(e.at));
        led_exp  = e.led;
        led_pend = 1'b1;
      end
    end
  end

  initial begin
    int t;
    rst      = 1'b1;
    key_next = 1'b1;
    key_prev = 1'b1;
    exp_mode = 0;
    repeat (3) @(negedge clk);
    check("reset_mode", 32'(mode), 32'd0);
    check("reset_led", 32'(led), 32'd0);
    check("reset_evt", 32'(key_evt), 32'd0);
    rst = 1'b0;

    // Idle blink: 8 cycles of AA, 8 of 55, then AA again.
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check("idle_blink", 32'(led), (((i - 1) / BLINK_CYC) % 2 == 1) ? 32'h55 : 32'hAA);
    end
    check("idle_mode", 32'(mode), 32'd0);

    // Four next presses: 1, 2, 3, wrap to 0.
    repeat (4) press(1'b1, 1'b0, 10, 10);
    check("wrap_mode", 32'(mode), 32'd0);

    // Two prev presses: 0 -> 3 -> 2.
    repeat (2) press(1'b0, 1'b1, 10, 10);
    check("prev_mode", 32'(mode), 32'd2);

    // Bounce: 2-cycle toggling, then a 3-cycle glitch; neither may register.
    for (int i = 0; i < 8; i++) begin
      key_next = 1'b0;
      repeat (2) @(negedge clk);
      key_next = 1'b1;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    key_next = 1'b0;
    repeat (3) @(negedge clk);
    key_next = 1'b1;
    repeat (12) @(negedge clk);
    check("bounce_mode", 32'(mode), 32'd2);

    // Long press from 2: step to 3, then long to 0.
    press(1'b1, 1'b0, 40, 10);
    check("long_mode", 32'(mode), 32'd0);
    // Back to 3, then a long press whose step lands in 0: the long adds nothing.
    press(1'b0, 1'b1, 10, 10);
    press(1'b1, 1'b0, 40, 10);
    check("long_in_idle_mode", 32'(mode), 32'd0);

    // Both keys together: no change.
    press(1'b1, 1'b1, 10, 10);
    check("both_keys_mode", 32'(mode), 32'd0);

    // Reset while next is held, then the held key registers again.
    @(negedge clk);
    key_next = 1'b0;
    t = cyc;
    sb_push(1, t + PRESS_LAT);
    repeat (12) @(negedge clk);
    rst      = 1'b1;
    exp_mode = 0;
    repeat (2) @(negedge clk);
    check("rst_hold_mode", 32'(mode), 32'd0);
    check("rst_hold_led", 32'(led), 32'd0);
    rst = 1'b0;
    t = cyc;
    sb_push(1, t + PRESS_LAT);
    repeat (12) @(negedge clk);
    key_next = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_redetect_mode", 32'(mode), 32'd1);
    check("rst_redetect_led", 32'(led), 32'h01);
    check("events_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
